icache: RTL and testbench
=========================

// Module: icache
// PURPOSE
//  Direct-mapped instruction cache between the IF stage and the memory controller.
//  Hits return a 32-bit instruction one cycle after request acceptance.
//  On a miss it issues one aligned 16-byte line fetch to the memory controller.
//  It then installs the returned 128-bit line and delivers the requested word.
// PARAMETERS
//  LINE_NUM  64  number of lines, power of two; IDX_W = log2(LINE_NUM); TAG_W = 32-4-IDX_W
// PORTS
//  clk           in   1    clock
//  rst           in   1    synchronous reset, active-high
//  rdy           in   1    global ready; 0 = accept no new requests
//  flush         in   1    pipeline flush (branch mispredict / rollback)
//  if_req_valid  in   1    IF presents a fetch request
//  if_req_pc     in   32   fetch address, word aligned
//  if_hit        out  1    1-cycle pulse: if_inst is valid
//  if_inst       out  32   returned instruction
//  mc_fc_valid   out  1    line fetch request to memory controller
//  mc_fc_addr    out  32   line address, {pc[31:4],4'b0}
//  mc_fc_done    in   1    1-cycle pulse: mc_fc_line valid
//  mc_fc_line    in   128  fetched line; byte k at bits [8k+7:8k]
// BEHAVIOUR
//  Address split: tag = pc[31:4+IDX_W], idx = pc[4+IDX_W-1:4], word = pc[3:2].
//  Storage: valid[LINE_NUM], tag[LINE_NUM], data[LINE_NUM] x 128b; lookup reads combinationally.
//  Reset (sync): state=IDLE, all valid=0, if_hit=0, if_inst=0, mc_fc_valid=0, mc_fc_addr=0, drop=0.
//  if_hit defaults to 0 every edge; it is set only as listed below.
//  Instruction select: inst = line[32*word +: 32].
//  States: IDLE, MISS.
//  IDLE, edge with rdy & if_req_valid & !flush: request is accepted.
//    hit (valid[idx] & tag match): if_hit<=1, if_inst<=inst; stay IDLE. Back-to-back hits are allowed, one per cycle.
//    miss: req_pc<=pc, mc_fc_valid<=1, mc_fc_addr<={pc[31:4],4'b0}, state<=MISS; if_hit stays 0.
//  IDLE, with !rdy or flush: no request is accepted and no state change occurs.
//  MISS: if_req_valid is ignored. mc_fc_valid and mc_fc_addr are held until mc_fc_done.
//  MISS, edge with mc_fc_done=1 (processed regardless of rdy):
//    install: valid[idx]<=1, tag[idx]<=tag, data[idx]<=mc_fc_line (idx and tag from req_pc).
//    mc_fc_valid<=0, so it is low the cycle after done. The controller never sees a stale request.
//    state<=IDLE.
//    if !drop & !flush: if_hit<=1, if_inst<=inst selected by req_pc[3:2]. drop<=0.
//  Miss latency: accept edge -> mc_fc_valid high next cycle -> if_hit the cycle after mc_fc_done.
//  flush in MISS: the fetch cannot be aborted because the memory controller has no cancel.
//    drop<=1; the line is still installed but no if_hit is issued.
//  flush and mc_fc_done on the same edge: the line is installed, no if_hit, drop<=0.
//  flush has priority over a same-cycle request. The cache never raises if_hit in the cycle after a flush.
//  rst in MISS: abandons the fetch; all outputs and valid bits return to reset values.
//  The memory controller resets on the same rst.
//  Only one outstanding fetch is ever issued. mc_fc_addr changes only on the IDLE->MISS edge.
// TESTING
//  T1 cold miss: after reset, request pc=0x10 ->
//     next cycle mc_fc_valid=1, mc_fc_addr=0x10.
//     Drive done with line=0x44444444_33333333_22222222_11111111 ->
//     next cycle if_hit=1, if_inst=0x11111111, mc_fc_valid=0.
//  T2 hit: after T1, request pc=0x1C ->
//     next cycle if_hit=1, if_inst=0x44444444. mc_fc_valid stays 0.
//     Back-to-back pc=0x14,0x18 -> hits returning 0x22222222, 0x33333333 on consecutive cycles.
//  T3 conflict (LINE_NUM=64): pc=0x410 (idx 1, different tag) -> miss with mc_fc_addr=0x410.
//     After fill, pc=0x10 misses again.
//  T4 flush during miss: pc=0x20 miss, flush 2 cycles later, done 10 cycles later -> no if_hit.
//     pc=0x24 next -> hit in 1 cycle.
//  T5 flush coincident with done -> no if_hit, line installed.
//     rdy=0 with if_req_valid=1 in IDLE -> no accept, mc_fc_valid stays 0.
//  T6 rst asserted while in MISS -> next cycle mc_fc_valid=0, if_hit=0.
//     Request to the line filled in T1 now misses.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped instruction cache. Hits return the instruction one cycle after
// the request is accepted. A miss fetches one 16-byte line from the memory controller.
module icache #(
   parameter int LINE_NUM = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic         flush,
   input  logic         if_req_valid,
   input  logic [31:0]  if_req_pc,
   output logic         if_hit,
   output logic [31:0]  if_inst,
   output logic         mc_fc_valid,
   output logic [31:0]  mc_fc_addr,
   input  logic         mc_fc_done,
   input  logic [127:0] mc_fc_line
);

   localparam int IDX_W = $clog2(LINE_NUM);
   localparam int TAG_W = 28 - IDX_W;

   typedef enum logic {
      IDLE,
      MISS
   } state_t;

   state_t              state_q, state_d;
   logic                if_hit_q, if_hit_d;
   logic [31:0]         if_inst_q, if_inst_d;
   logic                fc_valid_q, fc_valid_d;
   logic [31:0]         fc_addr_q, fc_addr_d;
   logic [31:2]         req_pc_q, req_pc_d;
   logic                drop_q, drop_d;

   logic [LINE_NUM-1:0] valid_q;
   logic [TAG_W-1:0]    tag_q  [LINE_NUM];
   logic [127:0]        data_q [LINE_NUM];

   logic [IDX_W-1:0]    lk_idx;
   logic [TAG_W-1:0]    lk_tag;
   logic                lk_hit;
   logic [127:0]        lk_line;
   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic                install;
   logic                unused_pc_bits;

   assign unused_pc_bits = &{1'b0, if_req_pc[1:0]};

   assign lk_idx  = if_req_pc[4 +: IDX_W];
   assign lk_tag  = if_req_pc[31 -: TAG_W];
   assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   assign lk_line = data_q[lk_idx];
   assign req_idx = req_pc_q[4 +: IDX_W];
   assign req_tag = req_pc_q[31 -: TAG_W];

   always_comb begin
      state_d    = state_q;
      if_hit_d   = 1'b0;
      if_inst_d  = if_inst_q;
      fc_valid_d = fc_valid_q;
      fc_addr_d  = fc_addr_q;
      req_pc_d   = req_pc_q;
      drop_d     = drop_q;
      install    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rdy && if_req_valid && !flush) begin
               if (lk_hit) begin
                  if_hit_d  = 1'b1;
                  if_inst_d = lk_line[{if_req_pc[3:2], 5'b0} +: 32];
               end else begin
                  req_pc_d   = if_req_pc[31:2];
                  fc_valid_d = 1'b1;
                  fc_addr_d  = {if_req_pc[31:4], 4'b0};
                  state_d    = MISS;
               end
            end
         end
         MISS: begin
            // The fetch cannot be cancelled, so a flush only suppresses delivery.
            if (mc_fc_done) begin
               install    = 1'b1;
               fc_valid_d = 1'b0;
               state_d    = IDLE;
               drop_d     = 1'b0;
               if (!drop_q && !flush) begin
                  if_hit_d  = 1'b1;
                  if_inst_d = mc_fc_line[{req_pc_q[3:2], 5'b0} +: 32];
               end
            end else if (flush) begin
               drop_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         if_hit_q   <= 1'b0;
         if_inst_q  <= '0;
         fc_valid_q <= 1'b0;
         fc_addr_q  <= '0;
         req_pc_q   <= '0;
         drop_q     <= 1'b0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         if_hit_q   <= if_hit_d;
         if_inst_q  <= if_inst_d;
         fc_valid_q <= fc_valid_d;
         fc_addr_q  <= fc_addr_d;
         req_pc_q   <= req_pc_d;
         drop_q     <= drop_d;
         if (install) begin
            valid_q[req_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays need no reset; the valid bits qualify them.
   always_ff @(posedge clk) begin
      if (install && !rst) begin
         tag_q[req_idx]  <= req_tag;
         data_q[req_idx] <= mc_fc_line;
      end
   end

   assign if_hit      = if_hit_q;
   assign if_inst     = if_inst_q;
   assign mc_fc_valid = fc_valid_q;
   assign mc_fc_addr  = fc_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: cold miss, hits, conflicts, flush handling,
// rdy gating and reset during a miss.
module tb_icache;

   logic         clk = 1'b0;
   logic         rst, rdy, flush, if_req_valid, mc_fc_done;
   logic [31:0]  if_req_pc;
   logic         if_hit, mc_fc_valid;
   logic [31:0]  if_inst, mc_fc_addr;
   logic [127:0] mc_fc_line;

   int unsigned  n_checks = 0;
   int unsigned  n_pass   = 0;

   icache #(.LINE_NUM(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .flush        (flush),
      .if_req_valid (if_req_valid),
      .if_req_pc    (if_req_pc),
      .if_hit       (if_hit),
      .if_inst      (if_inst),
      .mc_fc_valid  (mc_fc_valid),
      .mc_fc_addr   (mc_fc_addr),
      .mc_fc_done   (mc_fc_done),
      .mc_fc_line   (mc_fc_line)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic request(input logic [31:0] pc);
      if_req_pc    = pc;
      if_req_valid = 1'b1;
      tick();
      if_req_valid = 1'b0;
   endtask

   task automatic fill(input logic [127:0] line, input logic fl);
      mc_fc_line = line;
      mc_fc_done = 1'b1;
      flush      = fl;
      tick();
      mc_fc_done = 1'b0;
      flush      = 1'b0;
   endtask

   localparam logic [127:0] LINE1 = 128'h44444444_33333333_22222222_11111111;
   localparam logic [127:0] LINE3 = 128'hD3D3D3D3_C3C3C3C3_B3B3B3B3_A3A3A3A3;
   localparam logic [127:0] LINE4 = 128'hD4D4D4D4_C4C4C4C4_B4B4B4B4_A4A4A4A4;
   localparam logic [127:0] LINE5 = 128'hD5D5D5D5_C5C5C5C5_B5B5B5B5_A5A5A5A5;
   localparam logic [127:0] LINE6 = 128'hD6D6D6D6_C6C6C6C6_B6B6B6B6_A6A6A6A6;
   localparam logic [127:0] LINE7 = 128'hD7D7D7D7_C7C7C7C7_B7B7B7B7_A7A7A7A7;

   initial begin
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req_valid = 1'b0;
      if_req_pc = '0; mc_fc_done = 1'b0; mc_fc_line = '0;
      tick(); tick();
      rst = 1'b0;
      chk("rst_hit",   {31'b0, if_hit}, 32'h0);
      chk("rst_inst",  if_inst, 32'h0);
      chk("rst_fcv",   {31'b0, mc_fc_valid}, 32'h0);
      chk("rst_fca",   mc_fc_addr, 32'h0);

      // T1 cold miss
      request(32'h10);
      chk("t1_fcv",    {31'b0, mc_fc_valid}, 32'h1);
      chk("t1_fca",    mc_fc_addr, 32'h10);
      chk("t1_nohit",  {31'b0, if_hit}, 32'h0);
      tick();
      chk("t1_hold",   {31'b0, mc_fc_valid}, 32'h1);
      fill(LINE1, 1'b0);
      chk("t1_hit",    {31'b0, if_hit}, 32'h1);
      chk("t1_inst",   if_inst, 32'h11111111);
      chk("t1_fcv_lo", {31'b0, mc_fc_valid}, 32'h0);
      tick();
      chk("t1_pulse",  {31'b0, if_hit}, 32'h0);

      // T2 hits, back to back
      request(32'h1C);
      chk("t2_hit",    {31'b0, if_hit}, 32'h1);
      chk("t2_inst",   if_inst, 32'h44444444);
      chk("t2_fcv",    {31'b0, mc_fc_valid}, 32'h0);
      if_req_valid = 1'b1; if_req_pc = 32'h14;
      tick();
      chk("t2_b1_hit", {31'b0, if_hit}, 32'h1);
      chk("t2_b1",     if_inst, 32'h22222222);
      if_req_pc = 32'h18;
      tick();
      if_req_valid = 1'b0;
      chk("t2_b2_hit", {31'b0, if_hit}, 32'h1);
      chk("t2_b2",     if_inst, 32'h33333333);

      // T3 conflict on index 1
      request(32'h410);
      chk("t3_fcv",    {31'b0, mc_fc_valid}, 32'h1);
      chk("t3_fca",    mc_fc_addr, 32'h410);
      chk("t3_nohit",  {31'b0, if_hit}, 32'h0);
      fill(LINE3, 1'b0);
      chk("t3_inst",   if_inst, 32'hA3A3A3A3);
      request(32'h10);
      chk("t3_remiss", {31'b0, if_hit}, 32'h0);
      chk("t3_fca2",   mc_fc_addr, 32'h10);
      fill(LINE1, 1'b0);
      chk("t3_refill", if_inst, 32'h11111111);

      // T4 flush during miss
      request(32'h20);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t4_flush_nohit", {31'b0, if_hit}, 32'h0);
      for (int i = 0; i < 7; i++) tick();
      chk("t4_still_fcv", {31'b0, mc_fc_valid}, 32'h1);
      fill(LINE4, 1'b0);
      chk("t4_nohit",  {31'b0, if_hit}, 32'h0);
      chk("t4_fcv",    {31'b0, mc_fc_valid}, 32'h0);
      request(32'h24);
      chk("t4_hit",    {31'b0, if_hit}, 32'h1);
      chk("t4_inst",   if_inst, 32'hB4B4B4B4);

      // T5 flush with done
      request(32'h30);
      chk("t5_fcv",    {31'b0, mc_fc_valid}, 32'h1);
      fill(LINE5, 1'b1);
      chk("t5_nohit",  {31'b0, if_hit}, 32'h0);
      chk("t5_fcv_lo", {31'b0, mc_fc_valid}, 32'h0);
      request(32'h30);
      chk("t5_inst_hit", {31'b0, if_hit}, 32'h1);
      chk("t5_inst",   if_inst, 32'hA5A5A5A5);
      request(32'h4C);
      fill(LINE6, 1'b0);
      chk("t5_nodrop", {31'b0, if_hit}, 32'h1);
      chk("t5_nodrop_inst", if_inst, 32'hD6D6D6D6);
      // flush beats a same-cycle request to a resident line
      flush = 1'b1;
      request(32'h10);
      flush = 1'b0;
      chk("t5_flush_pri", {31'b0, if_hit}, 32'h0);
      // rdy low blocks acceptance of both misses and hits
      rdy = 1'b0;
      request(32'h50);
      tick();
      chk("t5_rdy_fcv", {31'b0, mc_fc_valid}, 32'h0);
      request(32'h10);
      chk("t5_rdy_hit", {31'b0, if_hit}, 32'h0);
      rdy = 1'b1;
      // done is processed even with rdy low
      request(32'h58);
      rdy = 1'b0;
      fill(LINE7, 1'b0);
      rdy = 1'b1;
      chk("t5_done_rdy", {31'b0, if_hit}, 32'h1);
      chk("t5_done_inst", if_inst, 32'hC7C7C7C7);

      // T6 reset during miss
      request(32'h60);
      chk("t6_fcv",    {31'b0, mc_fc_valid}, 32'h1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t6_fcv_lo", {31'b0, mc_fc_valid}, 32'h0);
      chk("t6_hit",    {31'b0, if_hit}, 32'h0);
      chk("t6_fca",    mc_fc_addr, 32'h0);
      request(32'h10);
      chk("t6_remiss", {31'b0, if_hit}, 32'h0);
      chk("t6_fcv2",   {31'b0, mc_fc_valid}, 32'h1);
      chk("t6_fca2",   mc_fc_addr, 32'h10);
      fill(LINE1, 1'b0);
      chk("t6_inst",   if_inst, 32'h11111111);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
